nic: RTL and testbench

Network interface controller between a processing element (PE) and the router's PE port. It exposes four memory-mapped words to the PE: input buffer, input status, output buffer and output status. It also runs the single-entry ready/send handshake with the router in both directions. Injection into the router is gated by the router's `polarity` signal, matched against the virtual-channel bit of the packet.

---
 rtl/nic_pkg.sv | 9 +
 rtl/nic_if.sv | 19 +
 rtl/nic_channel_buf.sv | 23 ++
 rtl/nic.sv | 47 ++++
 tb/tb_nic.sv | 129 ++++++++++++
 5 files changed

// File: rtl/nic_pkg.sv
// nic_pkg: address map and parameter defaults for the PE/router NIC.
package nic_pkg;
  localparam int NIC_DATA_WIDTH = 64;
  localparam int NIC_VC_BIT = 63;
  localparam logic [1:0] NIC_ADDR_IN_BUF = 2'b00;
  localparam logic [1:0] NIC_ADDR_IN_STAT = 2'b01;
  localparam logic [1:0] NIC_ADDR_OUT_BUF = 2'b10;
  localparam logic [1:0] NIC_ADDR_OUT_STAT = 2'b11;
endpackage

// File: rtl/nic_if.sv
// nic_if: PE register bus plus router ready/send handshake in both directions.
interface nic_if import nic_pkg::*; #(parameter int DATA_WIDTH = NIC_DATA_WIDTH);
  logic [1:0] addr;
  logic [DATA_WIDTH-1:0] d_in;
  logic [DATA_WIDTH-1:0] d_out;
  logic nicEn;
  logic nicWrEn;
  logic net_si;
  logic net_ri;
  logic [DATA_WIDTH-1:0] net_di;
  logic net_so;
  logic net_ro;
  logic [DATA_WIDTH-1:0] net_do;
  logic net_polarity;
  modport master (output addr, d_in, nicEn, nicWrEn, net_si, net_di, net_ro, net_polarity,
                  input d_out, net_ri, net_so, net_do);
  modport slave (input addr, d_in, nicEn, nicWrEn, net_si, net_di, net_ro, net_polarity,
                 output d_out, net_ri, net_so, net_do);
endinterface

// File: rtl/nic_channel_buf.sv
// nic_channel_buf: one-entry data register with full flag, load and clear strobes.
module nic_channel_buf #(parameter int DATA_WIDTH = 64) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  clr,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  full
);
  logic [DATA_WIDTH-1:0] data_d, data_q;
  logic full_d, full_q;
  always_comb begin
    data_d = load ? d : data_q;
    full_d = load ? 1'b1 : clr ? 1'b0 : full_q;
  end
  always_ff @(posedge clk) begin
    data_q <= reset ? '0 : data_d;
    full_q <= reset ? 1'b0 : full_d;
  end
  assign q = data_q;
  assign full = full_q;
endmodule

// File: rtl/nic.sv
// nic: PE-facing memory-mapped NIC with polarity-gated injection into the router.
// Optional NIC_IRQ_EN adds nic_irq, in_full delayed by one cycle.
module nic import nic_pkg::*; #(
  parameter int DATA_WIDTH = NIC_DATA_WIDTH,
  parameter int VC_BIT = NIC_VC_BIT
) (
  input logic clk,
  input logic reset,
  nic_if.slave bus
`ifdef NIC_IRQ_EN
  , output logic nic_irq
`endif
);
  logic rd, wr, in_full, out_full;
  logic [DATA_WIDTH-1:0] in_buf, out_buf, d_out_d, d_out_q;
  assign rd = bus.nicEn & ~bus.nicWrEn;
  assign wr = bus.nicEn & bus.nicWrEn;
  nic_channel_buf #(.DATA_WIDTH(DATA_WIDTH)) u_in (
    .clk, .reset,
    .load(bus.net_si & bus.net_ri),
    .clr(rd && bus.addr == NIC_ADDR_IN_BUF),
    .d(bus.net_di), .q(in_buf), .full(in_full)
  );
  nic_channel_buf #(.DATA_WIDTH(DATA_WIDTH)) u_out (
    .clk, .reset,
    .load(wr && bus.addr == NIC_ADDR_OUT_BUF && !out_full),
    .clr(bus.net_so),
    .d(bus.d_in), .q(out_buf), .full(out_full)
  );
  assign bus.net_ri = ~in_full & ~reset;
  assign bus.net_so = out_full & bus.net_ro & (bus.net_polarity == out_buf[VC_BIT]);
  assign bus.net_do = out_buf;
  always_comb begin
    d_out_d = !rd ? d_out_q :
              bus.addr == NIC_ADDR_IN_BUF   ? in_buf :
              bus.addr == NIC_ADDR_IN_STAT  ? {{(DATA_WIDTH-1){1'b0}}, in_full} :
              bus.addr == NIC_ADDR_OUT_STAT ? {{(DATA_WIDTH-1){1'b0}}, out_full} : '0;
  end
  always_ff @(posedge clk) d_out_q <= reset ? '0 : d_out_d;
  assign bus.d_out = d_out_q;
`ifdef NIC_IRQ_EN
  logic irq_d, irq_q;
  assign irq_d = in_full;
  always_ff @(posedge clk) irq_q <= reset ? 1'b0 : irq_d;
  assign nic_irq = irq_q;
`endif
endmodule

// File: tb/tb_nic.sv
// tb_nic: random and directed stimulus against a buffer-level NIC model with a scoreboard monitor.
module tb_nic;
  typedef struct {bit ri; bit so; logic [63:0] nd; bit irq;} net_t;
  logic clk = 0, reset = 1;
  nic_if bus ();
`ifdef NIC_IRQ_EN
  logic irq;
  nic dut (.clk(clk), .reset(reset), .bus(bus), .nic_irq(irq));
`else
  nic dut (.clk(clk), .reset(reset), .bus(bus));
`endif
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0;
  logic [63:0] rd_q[$];
  net_t net_q[$];
  bit m_in_full, m_out_full, m_irq, pol;
  logic [63:0] m_in_buf, m_out_buf;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic cyc(input bit rst, input bit en, input bit wr, input logic [1:0] a,
                     input logic [63:0] din, input bit si, input logic [63:0] di, input bit ro);
    net_t n;
    bit so, ri;
    logic [63:0] r;
    @(posedge clk);
    #1;
    reset = rst; bus.nicEn = en & ~rst; bus.nicWrEn = wr; bus.addr = a; bus.d_in = din;
    bus.net_si = si; bus.net_di = di; bus.net_ro = ro;
    pol = ~pol; bus.net_polarity = pol;
    if (rst) begin
      m_in_full = 0; m_out_full = 0; m_in_buf = 0; m_out_buf = 0; m_irq = 0;
      return;
    end
    ri = !m_in_full;
    so = m_out_full && ro && (pol == m_out_buf[63]);
    n = '{ri, so, m_out_buf, m_irq};
    net_q.push_back(n);
    if (en && !wr) begin
      r = a == 2'd0 ? m_in_buf : a == 2'd1 ? 64'(m_in_full) : a == 2'd3 ? 64'(m_out_full) : 64'd0;
      rd_q.push_back(r);
    end
    m_irq = m_in_full;
    if (en && !wr && a == 2'd0) m_in_full = 0;
    if (si && ri) begin m_in_buf = di; m_in_full = 1; end
    if (en && wr && a == 2'd2 && !m_out_full) begin m_out_buf = din; m_out_full = 1; end
    else if (so) m_out_full = 0;
  endtask
  task automatic idle(input bit ro);
    cyc(0, 0, 0, 2'd0, 64'd0, 0, 64'd0, ro);
  endtask
  task automatic rd(input logic [1:0] a);
    cyc(0, 1, 0, a, 64'd0, 0, 64'd0, 1);
  endtask
  task automatic wr_ob(input logic [63:0] v, input bit ro);
    cyc(0, 1, 1, 2'd2, v, 0, 64'd0, ro);
  endtask
  task automatic do_reset(input int n);
    repeat (n) cyc(1, 0, 0, 2'd0, 64'd0, 0, 64'd0, 0);
  endtask
  // Monitor: d_out checked every cycle (popped after a read, held otherwise), net outputs every non-reset cycle.
  bit rd_prev = 0, rst_prev = 1;
  logic [63:0] exp_d = '0;
  always @(negedge clk) begin
    net_t n;
    if (rst_prev) exp_d = '0;
    else if (rd_prev) begin
      if (rd_q.size() == 0) chk("rd_q_underflow", 64'd1, 64'd0);
      else exp_d = rd_q.pop_front();
    end
    chk("d_out", bus.d_out, exp_d);
    rd_prev = bus.nicEn & ~bus.nicWrEn & ~reset;
    rst_prev = reset;
    if (reset) begin
      chk("ri_in_reset", 64'(bus.net_ri), 64'd0);
      chk("so_in_reset", 64'(bus.net_so), 64'd0);
    end else if (net_q.size() == 0) chk("net_q_underflow", 64'd1, 64'd0);
    else begin
      n = net_q.pop_front();
      chk("net_ri", 64'(bus.net_ri), 64'(n.ri));
      chk("net_so", 64'(bus.net_so), 64'(n.so));
      chk("net_do", bus.net_do, n.nd);
`ifdef NIC_IRQ_EN
      chk("nic_irq", 64'(irq), 64'(n.irq));
`endif
    end
  end
  initial begin
    bus.nicEn = 0; bus.nicWrEn = 0; bus.addr = 0; bus.d_in = 0; bus.net_si = 0;
    bus.net_di = 0; bus.net_ro = 0; bus.net_polarity = 0; pol = 0;
    do_reset(3);
    rd(2'd1); rd(2'd3); idle(1);
    cyc(0, 0, 0, 2'd0, 64'd0, 1, 64'hDEAD_BEEF_0000_0001, 1);
    idle(1); rd(2'd1); rd(2'd0); idle(1); idle(1);
    wr_ob(64'h8000_0000_0000_00AA, 1);
    repeat (3) idle(1);
    rd(2'd3); idle(1);
    wr_ob(64'h0000_0000_0000_0BBB, 0);
    for (int i = 0; i < 10; i++) begin
      if (i == 4) wr_ob(64'h1, 0); else idle(0);
    end
    rd(2'd3);
    repeat (3) idle(1);
    wr_ob(64'h0000_0000_0000_0CCC, 1);
    repeat (4) wr_ob(64'h5, 1);
    rd(2'd3); repeat (3) idle(1); rd(2'd0);
    cyc(0, 1, 1, 2'd2, 64'h8000_0000_0000_0077, 1, 64'h1234, 0);
    idle(0);
    do_reset(2);
    rd(2'd1); rd(2'd3); rd(2'd0); idle(1);
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(99) == 0) do_reset(1);
      else cyc(0, $urandom_range(1) == 1, $urandom_range(1) == 1, 2'($urandom_range(3)),
               {$urandom, $urandom}, $urandom_range(1) == 1, {$urandom, $urandom},
               $urandom_range(9) < 7);
    end
    repeat (3) idle(1);
    @(negedge clk);
    #1;
    chk("rd_q_drained", 64'(rd_q.size()), 64'd0);
    chk("net_q_drained", 64'(net_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
